// File: rtl/apb_arb_pkg.sv
// Shared types and helpers for the APB arbitrating master.
//   apb_state_e : bus phase state (IDLE, SETUP, ACCESS)
//   rr_pick()   : round-robin winner search over up to MAX_REQ requesters
package apb_arb_pkg;

  localparam int unsigned MAX_REQ = 8;
  localparam int unsigned IDX_W   = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } rr_pick_t;

  // First set bit of valid at or above ptr, wrapping modulo n.
  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                       input logic [IDX_W-1:0]   ptr,
                                       input int unsigned        n);
    rr_pick_t    res;
    int unsigned cand;
    res = '0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      cand = (32'(ptr) + k) % n;
      if ((k < n) && !res.found && valid[IDX_W'(cand)]) begin
        res.found = 1'b1;
        res.idx   = IDX_W'(cand);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/apb_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req_valid_i : per-requester request
//   ptr_i       : highest-priority requester index
//   grant_o     : one-hot winner (zero when nobody requests)
//   idx_o       : winner index
//   found_o     : at least one requester is valid
module apb_rr_arbiter
  import apb_arb_pkg::*;
#(
  parameter  int unsigned NREQ = 2,
  localparam int unsigned IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_valid_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IW-1:0]   idx_o,
  output logic            found_o
);

  rr_pick_t pick;

  always_comb begin
    pick    = rr_pick(MAX_REQ'(req_valid_i), IDX_W'(ptr_i), NREQ);
    found_o = pick.found;
    idx_o   = IW'(pick.idx);
    grant_o = '0;
    if (pick.found) grant_o[idx_o] = 1'b1;
  end

endmodule

// File: rtl/apb_arb_master.sv
// APB master shared round-robin between NREQ local requesters.
// Optional ACCESS-phase timeout enabled by defining APB_TIMEOUT_EN.
//   PCLK, PRESET        : clock, synchronous active-high reset
//   req_valid/write/addr/wdata : flattened requester ports (slice i per requester)
//   req_ready           : one-hot grant, combinational in the arbitration cycle
//   rsp_valid/rdata/err : one-cycle completion pulse to the granted requester
//   PSEL..PWDATA        : APB request outputs
//   PRDATA/PREADY/PSLVERR : APB slave response inputs
module apb_arb_master
  import apb_arb_pkg::*;
#(
  parameter int unsigned AWIDTH      = 4,
  parameter int unsigned DWIDTH      = 8,
  parameter int unsigned NREQ        = 2,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic                     PCLK,
  input  logic                     PRESET,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ-1:0]          req_write,
  input  logic [NREQ*AWIDTH-1:0]   req_addr,
  input  logic [NREQ*DWIDTH-1:0]   req_wdata,
  output logic [NREQ-1:0]          req_ready,
  output logic [NREQ-1:0]          rsp_valid,
  output logic [DWIDTH-1:0]        rsp_rdata,
  output logic                     rsp_err,
  output logic                     PSEL,
  output logic                     PENABLE,
  output logic                     PWRITE,
  output logic [AWIDTH-1:0]        PADDR,
  output logic [DWIDTH-1:0]        PWDATA,
  input  logic [DWIDTH-1:0]        PRDATA,
  input  logic                     PREADY,
  input  logic                     PSLVERR
);

  localparam int unsigned IW = $clog2(NREQ);

  // Elaboration-time parameter sanity checks.
  if ((NREQ < 2) || (NREQ > MAX_REQ)) begin : g_bad_nreq
    $error("apb_arb_master: NREQ must be 2..8");
  end
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("apb_arb_master: TIMEOUT_CYC must be at least 1");
  end

  apb_state_e        state_q, state_d;
  logic [IW-1:0]     rr_q;
  logic [IW-1:0]     gnt_idx_q;
  logic [AWIDTH-1:0] paddr_q;
  logic [DWIDTH-1:0] pwdata_q;
  logic              pwrite_q;
  logic [NREQ-1:0]   rsp_valid_q;
  logic [DWIDTH-1:0] rsp_rdata_q;
  logic              rsp_err_q;

  logic [NREQ-1:0]   arb_grant;
  logic [IW-1:0]     arb_idx;
  logic              arb_found;
  logic              timeout_c;
  logic              done_c;
  logic              take_c;

  apb_rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req_valid_i (req_valid),
    .ptr_i       (rr_q),
    .grant_o     (arb_grant),
    .idx_o       (arb_idx),
    .found_o     (arb_found)
  );

`ifdef APB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] tmo_cnt_q;

  // Counts wait states of the current ACCESS phase; cleared outside ACCESS.
  always_ff @(posedge PCLK) begin
    if (PRESET || (state_q != ACCESS)) tmo_cnt_q <= '0;
    else if (!PREADY)                  tmo_cnt_q <= tmo_cnt_q + CW'(1);
  end

  // Last permitted wait cycle acts as a forced completion.
  assign timeout_c = (state_q == ACCESS) && !PREADY && (tmo_cnt_q == CW'(TIMEOUT_CYC - 1));
`else
  assign timeout_c = 1'b0;
`endif

  // Transfer completes this cycle; arbitration also runs here for back-to-back.
  assign done_c = (state_q == ACCESS) && (PREADY || timeout_c);
  assign take_c = !PRESET && arb_found && ((state_q == IDLE) || done_c);

  // State register.
  always_ff @(posedge PCLK) begin
    if (PRESET) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (take_c) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (done_c) state_d = take_c ? SETUP : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM-decoded outputs.
  always_comb begin
    PSEL      = 1'b0;
    PENABLE   = 1'b0;
    req_ready = '0;
    if (state_q != IDLE)  PSEL    = 1'b1;
    if (state_q == ACCESS) PENABLE = 1'b1;
    if (take_c)           req_ready = arb_grant;
  end

  // Request capture, pointer rotation and response routing.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      rr_q        <= '0;
      gnt_idx_q   <= '0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pwrite_q    <= 1'b0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      if (take_c) begin
        paddr_q   <= req_addr[arb_idx*AWIDTH +: AWIDTH];
        pwdata_q  <= req_wdata[arb_idx*DWIDTH +: DWIDTH];
        pwrite_q  <= req_write[arb_idx];
        gnt_idx_q <= arb_idx;
        rr_q      <= (arb_idx == IW'(NREQ - 1)) ? '0 : arb_idx + IW'(1);
      end
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      if (done_c) begin
        rsp_valid_q[gnt_idx_q] <= 1'b1;
        // Timeout forces an error with zero data; writes never return data.
        rsp_rdata_q <= (pwrite_q || timeout_c) ? '0 : PRDATA;
        rsp_err_q   <= timeout_c ? 1'b1 : PSLVERR;
      end
    end
  end

  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign PWRITE    = pwrite_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_arb_master.sv
// Directed, table-driven bench for apb_arb_master (NREQ=2, AWIDTH=4, DWIDTH=8).
module tb_apb_arb_master;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic [1:0]  req_valid, req_write, req_ready, rsp_valid;
  logic [7:0]  req_addr;
  logic [15:0] req_wdata;
  logic [7:0]  rsp_rdata;
  logic        rsp_err, PSEL, PENABLE, PWRITE;
  logic [3:0]  PADDR;
  logic [7:0]  PWDATA, PRDATA;
  logic        PREADY, PSLVERR;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 PCLK = ~PCLK;

  apb_arb_master dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  typedef struct {
    logic        rst;
    logic [1:0]  vld, wr;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic        pready;
    logic [7:0]  prdata;
    logic        pslverr;
    logic [1:0]  e_rr, e_rv;
    logic [7:0]  e_rdata;
    logic        e_err, e_psel, e_pen, e_pwr;
    logic [3:0]  e_paddr;
    logic [7:0]  e_pwdata;
  } vec_t;

  localparam int NV = 33;
  vec_t vecs [NV];

  function automatic vec_t mk(logic rst, logic [1:0] vld, logic [1:0] wr, logic [7:0] addr,
                              logic [15:0] wdata, logic pready, logic [7:0] prdata, logic pslverr,
                              logic [1:0] e_rr, logic [1:0] e_rv, logic [7:0] e_rdata, logic e_err,
                              logic e_psel, logic e_pen, logic e_pwr, logic [3:0] e_paddr,
                              logic [7:0] e_pwdata);
    vec_t v;
    v.rst = rst; v.vld = vld; v.wr = wr; v.addr = addr; v.wdata = wdata;
    v.pready = pready; v.prdata = prdata; v.pslverr = pslverr;
    v.e_rr = e_rr; v.e_rv = e_rv; v.e_rdata = e_rdata; v.e_err = e_err;
    v.e_psel = e_psel; v.e_pen = e_pen; v.e_pwr = e_pwr; v.e_paddr = e_paddr; v.e_pwdata = e_pwdata;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
  endtask

  task automatic drive(input logic rst, input logic [1:0] vld, input logic [1:0] wr,
                       input logic [7:0] addr, input logic [15:0] wdata,
                       input logic pready, input logic [7:0] prdata, input logic pslverr);
    PRESET = rst; req_valid = vld; req_write = wr; req_addr = addr; req_wdata = wdata;
    PREADY = pready; PRDATA = prdata; PSLVERR = pslverr;
  endtask

  initial begin
    logic [27:0] act, exp;
    logic [1:0]  e_rr, e_rv;
    logic        e_psel;
    int          acc_cyc;
    bit          seen;

    // rst vld wr addr wdata rdy prdata err | rr rv rdata err psel pen pwr paddr pwdata
    vecs[0]  = mk(1, 2'b00, 2'b00, 8'h00, 16'h0000, 0, 8'h00, 0, 2'b00, 2'b00, 8'h00, 0, 0, 0, 0, 4'h0, 8'h00);
    // single write from requester 0
    vecs[1]  = mk(0, 2'b01, 2'b01, 8'h03, 16'h00A5, 0, 8'h00, 0, 2'b01, 2'b00, 8'h00, 0, 0, 0, 0, 4'h0, 8'h00);
    vecs[2]  = mk(0, 2'b00, 2'b00, 8'h00, 16'h0000, 0, 8'h00, 0, 2'b00, 2'b00, 8'h00, 0, 1, 0, 1, 4'h3, 8'hA5);
    vecs[3]  = mk(0, 2'b00, 2'b00, 8'h00, 16'h0000, 1, 8'h00, 0, 2'b00, 2'b00, 8'h00, 0, 1, 1, 1, 4'h3, 8'hA5);
    vecs[4]  = mk(0, 2'b00, 2'b00, 8'h00, 16'h0000, 0, 8'h00, 0, 2'b00, 2'b01, 8'h00, 0, 0, 0, 1, 4'h3, 8'hA5);
    // read from requester 1 with three wait states
    vecs[5]  = mk(0, 2'b10, 2'b00, 8'h70, 16'h0000, 0, 8'h00, 0, 2'b10, 2'b00, 8'h00, 0, 0, 0, 1, 4'h3, 8'hA5);
    vecs[6]  = mk(0, 2'b00, 2'b00, 8'h00, 16'h0000, 0, 8'h00, 0, 2'b00, 2'b00, 8'h00, 0, 1, 0, 0, 4'h7, 8'h00);
    vecs[7]  = mk(0, 2'b00, 2'b00, 8'h00, 16'h0000, 0, 8'h00, 0, 2'b00, 2'b00, 8'h00, 0, 1, 1, 0, 4'h7, 8'h00);
    vecs[8]  = mk(0, 2'b00, 2'b00, 8'h00, 16'h0000, 0, 8'h00, 0, 2'b00, 2'b00, 8'h00, 0, 1, 1, 0, 4'h7, 8'h00);
    vecs[9]  = mk(0, 2'b00, 2'b00, 8'h00, 16'h0000, 0, 8'h00, 0, 2'b00, 2'b00, 8'h00, 0, 1, 1, 0, 4'h7, 8'h00);
    vecs[10] = mk(0, 2'b00, 2'b00, 8'h00, 16'h0000, 1, 8'h5C, 0, 2'b00, 2'b00, 8'h00, 0, 1, 1, 0, 4'h7, 8'h00);
    vecs[11] = mk(0, 2'b00, 2'b00, 8'h00, 16'h0000, 0, 8'h00, 0, 2'b00, 2'b10, 8'h5C, 0, 0, 0, 0, 4'h7, 8'h00);
    // contention: both requesters valid, strict rotation, PSEL stays high
    vecs[12] = mk(0, 2'b11, 2'b11, 8'h21, 16'h2211, 1, 8'h00, 0, 2'b01, 2'b00, 8'h00, 0, 0, 0, 0, 4'h7, 8'h00);
    vecs[13] = mk(0, 2'b11, 2'b11, 8'h21, 16'h2211, 1, 8'h00, 0, 2'b00, 2'b00, 8'h00, 0, 1, 0, 1, 4'h1, 8'h11);
    vecs[14] = mk(0, 2'b11, 2'b11, 8'h21, 16'h2211, 1, 8'h00, 0, 2'b10, 2'b00, 8'h00, 0, 1, 1, 1, 4'h1, 8'h11);
    vecs[15] = mk(0, 2'b11, 2'b11, 8'h21, 16'h2211, 1, 8'h00, 0, 2'b00, 2'b01, 8'h00, 0, 1, 0, 1, 4'h2, 8'h22);
    vecs[16] = mk(0, 2'b11, 2'b11, 8'h21, 16'h2211, 1, 8'h00, 0, 2'b01, 2'b00, 8'h00, 0, 1, 1, 1, 4'h2, 8'h22);
    vecs[17] = mk(0, 2'b11, 2'b11, 8'h21, 16'h2211, 1, 8'h00, 0, 2'b00, 2'b10, 8'h00, 0, 1, 0, 1, 4'h1, 8'h11);
    vecs[18] = mk(0, 2'b11, 2'b11, 8'h21, 16'h2211, 1, 8'h00, 0, 2'b10, 2'b00, 8'h00, 0, 1, 1, 1, 4'h1, 8'h11);
    vecs[19] = mk(0, 2'b00, 2'b00, 8'h00, 16'h0000, 0, 8'h00, 0, 2'b00, 2'b01, 8'h00, 0, 1, 0, 1, 4'h2, 8'h22);
    // slave error on requester 1's write
    vecs[20] = mk(0, 2'b00, 2'b00, 8'h00, 16'h0000, 1, 8'h00, 1, 2'b00, 2'b00, 8'h00, 0, 1, 1, 1, 4'h2, 8'h22);
    vecs[21] = mk(0, 2'b00, 2'b00, 8'h00, 16'h0000, 0, 8'h00, 0, 2'b00, 2'b10, 8'h00, 1, 0, 0, 1, 4'h2, 8'h22);
    // reset during a stalled ACCESS drops the transfer
    vecs[22] = mk(0, 2'b01, 2'b00, 8'h05, 16'h0000, 0, 8'h00, 0, 2'b01, 2'b00, 8'h00, 0, 0, 0, 1, 4'h2, 8'h22);
    vecs[23] = mk(0, 2'b00, 2'b00, 8'h00, 16'h0000, 0, 8'h00, 0, 2'b00, 2'b00, 8'h00, 0, 1, 0, 0, 4'h5, 8'h00);
    vecs[24] = mk(1, 2'b00, 2'b00, 8'h00, 16'h0000, 0, 8'h00, 0, 2'b00, 2'b00, 8'h00, 0, 1, 1, 0, 4'h5, 8'h00);
    vecs[25] = mk(0, 2'b00, 2'b00, 8'h00, 16'h0000, 0, 8'h00, 0, 2'b00, 2'b00, 8'h00, 0, 0, 0, 0, 4'h0, 8'h00);
    vecs[26] = mk(0, 2'b00, 2'b00, 8'h00, 16'h0000, 0, 8'h00, 0, 2'b00, 2'b00, 8'h00, 0, 0, 0, 0, 4'h0, 8'h00);
    // after reset the pointer is back at 0; PREADY in SETUP is ignored; write returns zero data
    vecs[27] = mk(0, 2'b11, 2'b01, 8'h9A, 16'h3CC3, 0, 8'h00, 0, 2'b01, 2'b00, 8'h00, 0, 0, 0, 0, 4'h0, 8'h00);
    vecs[28] = mk(0, 2'b10, 2'b01, 8'h9A, 16'h3CC3, 1, 8'h00, 0, 2'b00, 2'b00, 8'h00, 0, 1, 0, 1, 4'hA, 8'hC3);
    vecs[29] = mk(0, 2'b10, 2'b01, 8'h9A, 16'h3CC3, 1, 8'h77, 0, 2'b10, 2'b00, 8'h00, 0, 1, 1, 1, 4'hA, 8'hC3);
    vecs[30] = mk(0, 2'b00, 2'b00, 8'h00, 16'h0000, 0, 8'h00, 0, 2'b00, 2'b01, 8'h00, 0, 1, 0, 0, 4'h9, 8'h3C);
    vecs[31] = mk(0, 2'b00, 2'b00, 8'h00, 16'h0000, 1, 8'hE1, 0, 2'b00, 2'b00, 8'h00, 0, 1, 1, 0, 4'h9, 8'h3C);
    vecs[32] = mk(0, 2'b00, 2'b00, 8'h00, 16'h0000, 0, 8'h00, 0, 2'b00, 2'b10, 8'hE1, 0, 0, 0, 0, 4'h9, 8'h3C);

    drive(1'b1, 2'b00, 2'b00, 8'h00, 16'h0000, 1'b0, 8'h00, 1'b0);

    for (int i = 0; i < NV; i++) begin
      @(posedge PCLK); #1;
      drive(vecs[i].rst, vecs[i].vld, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
            vecs[i].pready, vecs[i].prdata, vecs[i].pslverr);
      @(negedge PCLK);
      // rdata/err only meaningful alongside rsp_valid
      act = {req_ready, rsp_valid, PSEL, PENABLE, PWRITE, PADDR, PWDATA,
             (vecs[i].e_rv != 2'b00) ? rsp_rdata : 8'h00,
             (vecs[i].e_rv != 2'b00) ? rsp_err : 1'b0};
      exp = {vecs[i].e_rr, vecs[i].e_rv, vecs[i].e_psel, vecs[i].e_pen, vecs[i].e_pwr,
             vecs[i].e_paddr, vecs[i].e_pwdata, vecs[i].e_rdata, vecs[i].e_err};
      chk("vec", i, 32'(act), 32'(exp));
    end

    // Single requester held valid: a grant every other cycle, PSEL never drops.
    for (int k = 0; k < 10; k++) begin
      @(posedge PCLK); #1;
      if (k == 0) drive(1'b0, 2'b01, 2'b00, 8'h04, 16'h0000, 1'b1, 8'h40, 1'b0);
      if (k == 8) req_valid = 2'b00;
      @(negedge PCLK);
      e_rr   = ((k % 2 == 0) && (k < 8)) ? 2'b01 : 2'b00;
      e_rv   = ((k >= 3) && (k % 2 == 1)) ? 2'b01 : 2'b00;
      e_psel = (k >= 1) && (k <= 8);
      chk("b2b", k, 32'({req_ready, rsp_valid, PSEL}), 32'({e_rr, e_rv, e_psel}));
      if (e_rv != 2'b00) chk("b2b_rdata", k, 32'(rsp_rdata), 32'h40);
    end

`ifdef APB_TIMEOUT_EN
    // Stalled slave: forced error completion after 16 ACCESS cycles.
    @(posedge PCLK); #1;
    drive(1'b0, 2'b01, 2'b00, 8'h06, 16'h0000, 1'b0, 8'hFF, 1'b0);
    @(posedge PCLK); #1;
    req_valid = 2'b00;
    acc_cyc = 0;
    seen    = 1'b0;
    for (int n = 0; n < 60 && !seen; n++) begin
      @(negedge PCLK);
      if (rsp_valid != 2'b00) seen = 1'b1;
      else begin
        if (PENABLE) acc_cyc++;
        @(posedge PCLK); #1;
      end
    end
    chk("tmo_seen", 0, 32'(seen), 32'd1);
    chk("tmo_access_cycles", 0, 32'(acc_cyc), 32'd16);
    chk("tmo_rsp", 0, 32'({rsp_valid, rsp_err, rsp_rdata, PSEL}), 32'({2'b01, 1'b1, 8'h00, 1'b0}));
`else
    acc_cyc = 0;
    seen    = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/apb_arb_master.md
Name: apb_arb_master

Overview:
- APB master that shares one APB bus (PSEL/PENABLE/PWRITE/PADDR/PWDATA out; PRDATA/PREADY/PSLVERR in) between NREQ local requesters.
- Round-robin arbitration, SETUP/ACCESS phase sequencing, wait-state handling, response routing back to the winning requester.
- Sits between the host-side request ports and the APB slave / address decoder.

Parameters:
- AWIDTH, 4, APB address width.
- DWIDTH, 8, APB data width.
- NREQ, 2, number of requesters (2..8).
- TIMEOUT_CYC, 16, ACCESS-phase wait limit; used only with APB_TIMEOUT_EN.

Ports:
- PCLK  in  1  clock.
- PRESET  in  1  reset.
- req_valid  in  NREQ  per-requester transfer request.
- req_write  in  NREQ  per-requester 1=write, 0=read.
- req_addr  in  NREQ*AWIDTH  flattened addresses; requester i at [i*AWIDTH +: AWIDTH].
- req_wdata  in  NREQ*DWIDTH  flattened write data.
- req_ready  out  NREQ  one-hot grant pulse; request accepted this cycle.
- rsp_valid  out  NREQ  one-hot, one-cycle completion pulse.
- rsp_rdata  out  DWIDTH  read data, valid with rsp_valid.
- rsp_err  out  1  PSLVERR (or timeout) status, valid with rsp_valid.
- PSEL, PENABLE, PWRITE  out  1 each  APB controls.
- PADDR  out  AWIDTH  APB address.
- PWDATA  out  DWIDTH  APB write data.
- PRDATA  in  DWIDTH  APB read data.
- PREADY  in  1  APB ready.
- PSLVERR  in  1  APB error.

Behaviour:
- Interface: one clock PCLK; reset PRESET is synchronous and active-high. All state updates on the PCLK rising edge.
- Reset values: PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, FSM=IDLE, rr pointer=0.
- FSM states:
  - IDLE: no transfer on the bus.
  - SETUP: PSEL=1, PENABLE=0.
  - ACCESS: PSEL=1, PENABLE=1.
- Arbitration is evaluated in IDLE, and in ACCESS in the cycle PREADY=1.
  - Winner: first i with req_valid[i]=1, searching from rr pointer upward with wrap.
  - req_ready[winner] is driven combinationally high in that cycle. Requester must hold valid/write/addr/wdata stable until req_ready.
  - On grant, register PADDR/PWRITE/PWDATA from the winner's slice, record the grant index, set rr pointer = winner+1 mod NREQ, and go to SETUP.
- SETUP always lasts exactly one cycle, then ACCESS. PADDR/PWRITE/PWDATA stay constant through SETUP and ACCESS.
- ACCESS with PREADY=0: hold all APB outputs (wait state, unbounded unless timeout).
- ACCESS with PREADY=1:
  - Next cycle: rsp_valid[grant]=1, rsp_rdata=PRDATA (0 for writes), rsp_err=PSLVERR.
  - If any req_valid is high, re-arbitrate and go directly to SETUP (back-to-back transfer, PSEL stays 1, PENABLE drops to 0). Otherwise go to IDLE.
- Latency: request seen in IDLE at cycle 0 → SETUP cycle 1 → ACCESS cycle 2 → rsp_valid cycle 3 (zero wait states). Each wait state adds one cycle.
- A requester may re-request in the cycle its rsp_valid is high. Its req_valid is ignored while its own transfer is outstanding.
- PREADY and PSLVERR are ignored outside ACCESS.
- PRESET mid-transfer: bus returns to reset values next cycle; the outstanding transfer is dropped with no rsp_valid.
- Single requester: continuous back-to-back transfers of 2 cycles each.
- All requesters active: strict rotation 0,1,…,NREQ-1,0.

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to ACCESS and increments each ACCESS cycle with PREADY=0.
  - When it reaches TIMEOUT_CYC, the transfer is forced complete: rsp_valid pulse with rsp_err=1, rsp_rdata=0, then the normal next-state decision (PSEL deasserts unless back-to-back).
- Undefined: no counter; ACCESS waits indefinitely on PREADY.

Decomposition:
- Package apb_arb_pkg: state enum (IDLE, SETUP, ACCESS), and function rr_pick(valid, ptr) returning the winner index plus a found flag.
- One sub-module: apb_rr_arbiter (NREQ param; inputs req_valid, ptr; outputs one-hot grant and index). Combinational, reused by other arbiters in the design.
- FSM, datapath registers and timeout counter stay in apb_arb_master.

Test Plan:
- Single write: req0 write addr=4'h3 wdata=8'hA5, PREADY=1 → SETUP cycle 1, ACCESS cycle 2 with PADDR=3, PWDATA=A5; rsp_valid=01 cycle 3, rsp_err=0.
- Read with 3 wait states: req1 read addr=4'h7, PRDATA=8'h5C at PREADY → PENABLE high 4 cycles; rsp_valid=10, rsp_rdata=5C.
- Contention: req0 and req1 both valid continuously, 4 transfers → grant order 0,1,0,1; PSEL never drops; each transfer takes 2 cycles.
- Slave error: PSLVERR=1 with PREADY on a write → rsp_err=1 on that requester's rsp_valid only.
- Reset mid-ACCESS: PRESET=1 while PREADY=0 → next cycle all outputs 0; no rsp_valid; a new request afterwards completes normally.
- APB_TIMEOUT_EN, TIMEOUT_CYC=16, PREADY held 0 → rsp_valid with rsp_err=1 after 16 ACCESS cycles; PSEL=0 the following cycle.
